// File: rtl/dsi_pixel_unpacker.sv
// RGB888 payload unpacker: groups of three DSI payload bytes become one 24-bit
// pixel, buffered in a small FIFO that the display timing stage pops.
module dsi_pixel_unpacker #(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          sof,
  input  logic          byte_valid,
  input  logic [7:0]    byte_data,
  output logic          byte_ready,
  input  logic          pix_rd,
  output logic [23:0]   pixel_data,
  output logic          pixel_valid,
  output logic [AW:0]   fifo_level,
  output logic          overflow,
  output logic          underflow
);

  localparam logic [AW:0] FULL_LEVEL = (AW + 1)'(DEPTH);

  typedef enum logic [1:0] {
    PH_R = 2'd0,
    PH_G = 2'd1,
    PH_B = 2'd2
  } phase_e;

  phase_e        phase_q, phase_d;
  logic [7:0]    hold_r, hold_g;
  logic [23:0]   mem [DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic [AW:0]   count;
  logic          fifo_empty;
  logic          accept;
  logic          wr_en;
  logic          rd_en;

  // byte_ready uses the count before any same-cycle sof flush.
  assign byte_ready = (count != FULL_LEVEL);
  assign fifo_empty = (count == '0);
  assign accept     = byte_valid && byte_ready;
  assign wr_en      = accept && (phase_q == PH_B) && !sof;
  assign rd_en      = pix_rd && !fifo_empty && !sof;
  assign fifo_level = count;

  // NOTE: always_comb assigns every output a default first so no latch is inferred.
  always_comb begin
    phase_d = phase_q;
    if (sof) begin
      phase_d = accept ? PH_G : PH_R;
    end else if (accept) begin
      case (phase_q)
        PH_R:    phase_d = PH_G;
        PH_G:    phase_d = PH_B;
        default: phase_d = PH_R;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      phase_q <= PH_R;
    end else begin
      phase_q <= phase_d;
    end
  end

  // A byte arriving with sof is the red byte of the new frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      hold_r <= '0;
      hold_g <= '0;
    end else if (accept) begin
      if (sof || phase_q == PH_R) begin
        hold_r <= byte_data;
      end else if (phase_q == PH_G) begin
        hold_g <= byte_data;
      end
    end
  end

  // NOTE: the storage array has no reset; pointers and count define which entries are valid.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wptr] <= {hold_r, hold_g, byte_data};
    end
  end

  always_ff @(posedge clk) begin
    if (rst || sof) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (wr_en) begin
        wptr <= wptr + 1'b1;
      end
      if (rd_en) begin
        rptr <= rptr + 1'b1;
      end
      case ({wr_en, rd_en})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Empty pops and pops swallowed by sof drive black; otherwise data holds.
  always_ff @(posedge clk) begin
    if (rst) begin
      pixel_data  <= '0;
      pixel_valid <= 1'b0;
    end else begin
      pixel_valid <= rd_en;
      if (rd_en) begin
        pixel_data <= mem[rptr];
      end else if (pix_rd) begin
        pixel_data <= '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (byte_valid && !byte_ready) begin
        overflow <= 1'b1;
      end
      if (pix_rd && fifo_empty && !sof) begin
        underflow <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_dsi_pixel_unpacker.sv
// Directed self-checking bench for dsi_pixel_unpacker with hand-computed
// expected pixels, levels and flag states.
module tb_dsi_pixel_unpacker;

  localparam int DEPTH = 16;
  localparam int AW    = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          sof;
  logic          byte_valid;
  logic [7:0]    byte_data;
  logic          byte_ready;
  logic          pix_rd;
  logic [23:0]   pixel_data;
  logic          pixel_valid;
  logic [AW:0]   fifo_level;
  logic          overflow;
  logic          underflow;

  int n_checks = 0;
  int n_errors = 0;

  dsi_pixel_unpacker #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk         (clk),
    .rst         (rst),
    .sof         (sof),
    .byte_valid  (byte_valid),
    .byte_data   (byte_data),
    .byte_ready  (byte_ready),
    .pix_rd      (pix_rd),
    .pixel_data  (pixel_data),
    .pixel_valid (pixel_valid),
    .fifo_level  (fifo_level),
    .overflow    (overflow),
    .underflow   (underflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    byte_valid = 1'b1;
    byte_data  = b;
    tick();
    byte_valid = 1'b0;
  endtask

  task automatic pop();
    pix_rd = 1'b1;
    tick();
    pix_rd = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    int tb_level;
    int bytes_sent;
    int popped;
    int cyc;
    logic popping;
    logic [7:0] b;

    rst = 1'b0; sof = 1'b0; byte_valid = 1'b0; byte_data = '0; pix_rd = 1'b0;

    // Reset state
    do_reset();
    check("rst_pixel_data", 32'(pixel_data), 32'h0);
    check("rst_pixel_valid", 32'(pixel_valid), 32'h0);
    check("rst_level", 32'(fifo_level), 32'd0);
    check("rst_byte_ready", 32'(byte_ready), 32'd1);
    check("rst_overflow", 32'(overflow), 32'd0);
    check("rst_underflow", 32'(underflow), 32'd0);

    // Pack order
    send_byte(8'h11); send_byte(8'h22); send_byte(8'h33);
    check("pack_level1", 32'(fifo_level), 32'd1);
    send_byte(8'hAA); send_byte(8'hBB); send_byte(8'hCC);
    check("pack_level2", 32'(fifo_level), 32'd2);
    pop();
    check("pack_pix0", 32'(pixel_data), 32'h112233);
    check("pack_valid0", 32'(pixel_valid), 32'd1);
    check("pack_level_after_pop0", 32'(fifo_level), 32'd1);
    pop();
    check("pack_pix1", 32'(pixel_data), 32'hAABBCC);
    check("pack_valid1", 32'(pixel_valid), 32'd1);
    check("pack_level_after_pop1", 32'(fifo_level), 32'd0);
    tick();
    check("idle_valid_low", 32'(pixel_valid), 32'd0);
    check("idle_data_hold", 32'(pixel_data), 32'hAABBCC);

    // Fill to full, then overflow
    for (int i = 0; i < 3 * DEPTH; i++) send_byte(8'(i));
    check("full_level", 32'(fifo_level), 32'd16);
    check("full_byte_ready", 32'(byte_ready), 32'd0);
    check("full_no_overflow_yet", 32'(overflow), 32'd0);
    send_byte(8'hEE);
    check("ovf_flag", 32'(overflow), 32'd1);
    check("ovf_level_held", 32'(fifo_level), 32'd16);
    byte_valid = 1'b1; byte_data = 8'hEF; pix_rd = 1'b1;
    tick();
    byte_valid = 1'b0; pix_rd = 1'b0;
    check("full_rd_wr_level", 32'(fifo_level), 32'd15);
    check("full_rd_data", 32'(pixel_data), 32'h000102);
    check("full_rd_valid", 32'(pixel_valid), 32'd1);
    check("after_rd_byte_ready", 32'(byte_ready), 32'd1);

    // sof with a pop in the same cycle: pop ignored, flush, flags sticky
    sof = 1'b1; pix_rd = 1'b1;
    tick();
    sof = 1'b0; pix_rd = 1'b0;
    check("sof_rd_data_black", 32'(pixel_data), 32'h0);
    check("sof_rd_valid", 32'(pixel_valid), 32'd0);
    check("sof_level", 32'(fifo_level), 32'd0);
    check("sof_no_underflow", 32'(underflow), 32'd0);
    check("sof_overflow_sticky", 32'(overflow), 32'd1);

    // Underflow
    do_reset();
    send_byte(8'h55); send_byte(8'h66); send_byte(8'h77);
    pop();
    check("uf_pre_data", 32'(pixel_data), 32'h556677);
    pop();
    check("uf_data_black", 32'(pixel_data), 32'h0);
    check("uf_valid", 32'(pixel_valid), 32'd0);
    check("uf_flag", 32'(underflow), 32'd1);
    send_byte(8'h01); send_byte(8'h02); send_byte(8'h03);
    pop();
    check("uf_good_data", 32'(pixel_data), 32'h010203);
    check("uf_good_valid", 32'(pixel_valid), 32'd1);
    check("uf_sticky", 32'(underflow), 32'd1);

    // sof mid-pixel
    do_reset();
    send_byte(8'h01); send_byte(8'h02);
    sof = 1'b1;
    send_byte(8'h10);
    sof = 1'b0;
    check("sofmid_level", 32'(fifo_level), 32'd0);
    send_byte(8'h20); send_byte(8'h30);
    check("sofmid_level1", 32'(fifo_level), 32'd1);
    pop();
    check("sofmid_pixel", 32'(pixel_data), 32'h102030);
    check("sofmid_valid", 32'(pixel_valid), 32'd1);

    // Wrap-around: 40 pixels streamed, pops on odd cycles while the bench model is non-empty
    do_reset();
    tb_level = 0; bytes_sent = 0; popped = 0; cyc = 0;
    while (popped < 40 && cyc < 400) begin
      popping = (cyc % 2 == 1) && (tb_level > 0);
      pix_rd = popping;
      if (bytes_sent < 120) begin
        b = (bytes_sent % 3 == 2) ? 8'(bytes_sent / 3 + 1) : 8'h00;
        byte_valid = 1'b1;
        byte_data  = b;
      end else begin
        byte_valid = 1'b0;
      end
      tick();
      if (byte_valid) begin
        if (bytes_sent % 3 == 2) tb_level++;
        bytes_sent++;
      end
      if (popping) begin
        tb_level--;
        popped++;
        check($sformatf("wrap_pix%0d", popped), 32'({pixel_valid, pixel_data}), 32'h0100_0000 | 32'(popped));
      end
      cyc++;
    end
    byte_valid = 1'b0; pix_rd = 1'b0;
    check("wrap_popped_all", 32'(popped), 32'd40);
    check("wrap_level_zero", 32'(fifo_level), 32'd0);
    check("wrap_no_overflow", 32'(overflow), 32'd0);
    check("wrap_no_underflow", 32'(underflow), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
